// File: rtl/pong_game_core.sv
// Two-player pong engine: paddles, ball physics, serve, scoring, pause and game-over.
// State advances only on frame_tick; all outputs are registered.
module pong_game_core #(
   parameter int FIELD_W   = 640,
   parameter int FIELD_H   = 480,
   parameter int P1_X      = 40,
   parameter int P2_X      = 600,
   parameter int PAD_W     = 8,
   parameter int PAD_H     = 50,
   parameter int BALL_SZ   = 8,
   parameter int P_SPD     = 16,
   parameter int BX_SPD    = 8,
   parameter int BY_SPD    = 8,
   parameter int WIN_SCORE = 9,
   parameter int PAUSE_FR  = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       p1_up,
   input  logic       p1_dn,
   input  logic       p2_up,
   input  logic       p2_dn,
   input  logic       p1_srv,
   input  logic       p2_srv,
   output logic [8:0] p1_y,
   output logic [8:0] p2_y,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [2:0] state,
   output logic       beep_pad,
   output logic       beep_wall,
   output logic       beep_score
);

   localparam logic [2:0] StServeP1  = 3'd0;
   localparam logic [2:0] StServeP2  = 3'd1;
   localparam logic [2:0] StPlay     = 3'd2;
   localparam logic [2:0] StPoint    = 3'd3;
   localparam logic [2:0] StGameOver = 3'd4;

   localparam int CntW = (PAUSE_FR > 1) ? $clog2(PAUSE_FR) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(PAUSE_FR - 1);
   localparam logic [3:0] WinScore = 4'(WIN_SCORE);

   localparam logic signed [10:0] PSpd     = 11'(P_SPD);
   localparam logic signed [10:0] BxSpd    = 11'(BX_SPD);
   localparam logic signed [10:0] BySpd    = 11'(BY_SPD);
   localparam logic signed [10:0] HalfBall = 11'(BALL_SZ / 2);
   localparam logic signed [10:0] PadMin   = 11'(PAD_H / 2);
   localparam logic signed [10:0] PadMax   = 11'(FIELD_H - 1 - PAD_H / 2);
   localparam logic signed [10:0] P1Face   = 11'(P1_X + PAD_W / 2);
   localparam logic signed [10:0] P2Face   = 11'(P2_X - PAD_W / 2);
   localparam logic signed [10:0] P1ParkX  = P1Face + HalfBall;
   localparam logic signed [10:0] P2ParkX  = P2Face - HalfBall;
   localparam logic signed [10:0] HitRange = 11'((PAD_H + BALL_SZ) / 2);
   localparam logic signed [10:0] FieldWm1 = 11'(FIELD_W - 1);
   localparam logic signed [10:0] FieldHm1 = 11'(FIELD_H - 1);
   localparam logic signed [10:0] YMid     = 11'(FIELD_H / 2);

   logic [8:0]      p1_y_q, p1_y_d, p2_y_q, p2_y_d, ball_y_q, ball_y_d;
   logic [9:0]      ball_x_q, ball_x_d;
   logic [3:0]      score1_q, score1_d, score2_q, score2_d;
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
   logic            p2_scored_q, p2_scored_d;
   logic            p1_srv_q, p2_srv_q;
   logic            srv1_pend_q, srv1_pend_d, srv2_pend_q, srv2_pend_d;
   logic            beep_pad_q, beep_pad_d, beep_wall_q, beep_wall_d;
   logic            beep_score_q, beep_score_d;

   logic                   srv1_evt, srv2_evt, hit1, hit2;
   logic [8:0]             p1_new, p2_new;
   logic signed [10:0]     bx, by, nx, ny, dy1, dy2;

   function automatic logic [8:0] pad_step(input logic [8:0] y, input logic up,
                                           input logic dn);
      logic signed [10:0] t;
      t = signed'({2'b00, y});
      if (up && !dn) t = t - PSpd;
      else if (dn && !up) t = t + PSpd;
      if (t < PadMin) t = PadMin;
      else if (t > PadMax) t = PadMax;
      return t[8:0];
   endfunction

   always_comb begin
      p1_y_d       = p1_y_q;
      p2_y_d       = p2_y_q;
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      score1_d     = score1_q;
      score2_d     = score2_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      vx_neg_d     = vx_neg_q;
      vy_neg_d     = vy_neg_q;
      p2_scored_d  = p2_scored_q;
      beep_pad_d   = 1'b0;
      beep_wall_d  = 1'b0;
      beep_score_d = 1'b0;

      // Serve edges between ticks are held until the next tick consumes them.
      srv1_evt    = srv1_pend_q | (p1_srv & ~p1_srv_q);
      srv2_evt    = srv2_pend_q | (p2_srv & ~p2_srv_q);
      srv1_pend_d = srv1_evt & ~frame_tick;
      srv2_pend_d = srv2_evt & ~frame_tick;

      p1_new = pad_step(p1_y_q, p1_up, p1_dn);
      p2_new = pad_step(p2_y_q, p2_up, p2_dn);

      bx  = signed'({1'b0, ball_x_q});
      by  = signed'({2'b00, ball_y_q});
      nx  = vx_neg_q ? bx - BxSpd : bx + BxSpd;
      ny  = vy_neg_q ? by - BySpd : by + BySpd;
      dy1 = ny - signed'({2'b00, p1_y_q});
      dy2 = ny - signed'({2'b00, p2_y_q});
      hit1 = vx_neg_q && (bx - HalfBall > P1Face) && (nx - HalfBall <= P1Face) &&
             (dy1 <= HitRange) && (dy1 >= -HitRange);
      hit2 = !vx_neg_q && (bx + HalfBall < P2Face) && (nx + HalfBall >= P2Face) &&
             (dy2 <= HitRange) && (dy2 >= -HitRange);

      if (frame_tick) begin
         case (state_q)
            StServeP1: begin
               p1_y_d   = p1_new;
               p2_y_d   = p2_new;
               ball_x_d = 10'(P1ParkX);
               ball_y_d = p1_new;
               if (srv1_evt) begin
                  state_d  = StPlay;
                  vx_neg_d = 1'b0;
               end
            end
            StServeP2: begin
               p1_y_d   = p1_new;
               p2_y_d   = p2_new;
               ball_x_d = 10'(P2ParkX);
               ball_y_d = p2_new;
               if (srv2_evt) begin
                  state_d  = StPlay;
                  vx_neg_d = 1'b1;
               end
            end
            StPlay: begin
               p1_y_d = p1_new;
               p2_y_d = p2_new;
               if (nx - HalfBall <= 11'sd0) begin
                  score2_d     = (score2_q == WinScore) ? score2_q : score2_q + 4'd1;
                  p2_scored_d  = 1'b1;
                  beep_score_d = 1'b1;
                  state_d      = StPoint;
                  cnt_d        = '0;
               end else if (nx + HalfBall >= FieldWm1) begin
                  score1_d     = (score1_q == WinScore) ? score1_q : score1_q + 4'd1;
                  p2_scored_d  = 1'b0;
                  beep_score_d = 1'b1;
                  state_d      = StPoint;
                  cnt_d        = '0;
               end else begin
                  ball_x_d = nx[9:0];
                  ball_y_d = ny[8:0];
                  if (hit1) begin
                     ball_x_d   = 10'(P1ParkX);
                     vx_neg_d   = 1'b0;
                     beep_pad_d = 1'b1;
                  end else if (hit2) begin
                     ball_x_d   = 10'(P2ParkX);
                     vx_neg_d   = 1'b1;
                     beep_pad_d = 1'b1;
                  end
                  if (ny - HalfBall < 11'sd0) begin
                     ball_y_d    = 9'(HalfBall);
                     vy_neg_d    = 1'b0;
                     beep_wall_d = 1'b1;
                  end else if (ny + HalfBall > FieldHm1) begin
                     ball_y_d    = 9'(FieldHm1 - HalfBall);
                     vy_neg_d    = 1'b1;
                     beep_wall_d = 1'b1;
                  end
               end
            end
            StPoint: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  // The conceding player serves next unless the scorer has just won.
                  if (p2_scored_q) begin
                     if (score2_q == WinScore) begin
                        state_d = StGameOver;
                     end else begin
                        state_d  = StServeP1;
                        ball_x_d = 10'(P1ParkX);
                        ball_y_d = p1_y_q;
                     end
                  end else begin
                     if (score1_q == WinScore) begin
                        state_d = StGameOver;
                     end else begin
                        state_d  = StServeP2;
                        ball_x_d = 10'(P2ParkX);
                        ball_y_d = p2_y_q;
                     end
                  end
               end
            end
            StGameOver: begin
               if (srv1_evt || srv2_evt) begin
                  score1_d = '0;
                  score2_d = '0;
                  p1_y_d   = 9'(YMid);
                  p2_y_d   = 9'(YMid);
                  ball_x_d = 10'(P1ParkX);
                  ball_y_d = 9'(YMid);
                  state_d  = StServeP1;
               end
            end
            default: state_d = StServeP1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_y_q       <= 9'(YMid);
         p2_y_q       <= 9'(YMid);
         ball_x_q     <= 10'(P1ParkX);
         ball_y_q     <= 9'(YMid);
         score1_q     <= '0;
         score2_q     <= '0;
         state_q      <= StServeP1;
         cnt_q        <= '0;
         vx_neg_q     <= 1'b0;
         vy_neg_q     <= 1'b0;
         p2_scored_q  <= 1'b0;
         p1_srv_q     <= 1'b0;
         p2_srv_q     <= 1'b0;
         srv1_pend_q  <= 1'b0;
         srv2_pend_q  <= 1'b0;
         beep_pad_q   <= 1'b0;
         beep_wall_q  <= 1'b0;
         beep_score_q <= 1'b0;
      end else begin
         p1_y_q       <= p1_y_d;
         p2_y_q       <= p2_y_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vx_neg_q     <= vx_neg_d;
         vy_neg_q     <= vy_neg_d;
         p2_scored_q  <= p2_scored_d;
         p1_srv_q     <= p1_srv;
         p2_srv_q     <= p2_srv;
         srv1_pend_q  <= srv1_pend_d;
         srv2_pend_q  <= srv2_pend_d;
         beep_pad_q   <= beep_pad_d;
         beep_wall_q  <= beep_wall_d;
         beep_score_q <= beep_score_d;
      end
   end

   assign p1_y       = p1_y_q;
   assign p2_y       = p2_y_q;
   assign ball_x     = ball_x_q;
   assign ball_y     = ball_y_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign state      = state_q;
   assign beep_pad   = beep_pad_q;
   assign beep_wall  = beep_wall_q;
   assign beep_score = beep_score_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Bench for pong_game_core: frame-level game model compared every cycle, plus literal checkpoints.
module tb_pong_game_core;

   localparam int FW = 640, FH = 480, P1X = 40, P2X = 600, PW = 8, PH = 50, BS = 8;
   localparam int PS = 16, BXS = 8, BYS = 8, WIN = 9, PF = 60;
   localparam int LFACE = P1X + PW / 2, RFACE = P2X - PW / 2;
   localparam int YMIN = PH / 2, YMAX = FH - 1 - PH / 2;

   logic       clk, rst, frame_tick;
   logic       p1_up, p1_dn, p2_up, p2_dn, p1_srv, p2_srv;
   logic [8:0] p1_y, p2_y, ball_y;
   logic [9:0] ball_x;
   logic [3:0] score1, score2;
   logic [2:0] state;
   logic       beep_pad, beep_wall, beep_score;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   pong_game_core dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
      .p1_srv(p1_srv), .p2_srv(p2_srv),
      .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
      .score1(score1), .score2(score2), .state(state),
      .beep_pad(beep_pad), .beep_wall(beep_wall), .beep_score(beep_score)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Frame ticks with a random gap of 0..3 idle cycles.
   initial begin
      int gap;
      gap = 0;
      frame_tick = 0;
      forever begin
         @(negedge clk);
         if (gap == 0) begin
            frame_tick = 1;
            gap = $urandom_range(0, 3);
         end else begin
            frame_tick = 0;
            gap--;
         end
      end
   end

   // ---------------- behavioural model ----------------
   int m_p1y, m_p2y, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_st, m_cnt, m_last;
   bit m_bp, m_bw, m_bs, m_prev1, m_prev2, m_pend1, m_pend2, e1, e2;

   function automatic int pad(input int y, input bit up, input bit dn);
      int t = y;
      if (up && !dn) t -= PS;
      else if (dn && !up) t += PS;
      if (t < YMIN) t = YMIN;
      if (t > YMAX) t = YMAX;
      return t;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_frame(input bit s1ev, input bit s2ev);
      int nx, ny, op1, op2;
      case (m_st)
         0, 1: begin
            m_p1y = pad(m_p1y, p1_up, p1_dn);
            m_p2y = pad(m_p2y, p2_up, p2_dn);
            if (m_st == 0) begin
               m_bx = LFACE + BS / 2;
               m_by = m_p1y;
               if (s1ev) begin m_st = 2; m_vx = 1; end
            end else begin
               m_bx = RFACE - BS / 2;
               m_by = m_p2y;
               if (s2ev) begin m_st = 2; m_vx = -1; end
            end
         end
         2: begin
            op1 = m_p1y;
            op2 = m_p2y;
            m_p1y = pad(m_p1y, p1_up, p1_dn);
            m_p2y = pad(m_p2y, p2_up, p2_dn);
            nx = m_bx + m_vx * BXS;
            ny = m_by + m_vy * BYS;
            if (nx - BS / 2 <= 0) begin
               if (m_s2 < WIN) m_s2++;
               m_last = 2; m_bs = 1; m_st = 3; m_cnt = 0;
            end else if (nx + BS / 2 >= FW - 1) begin
               if (m_s1 < WIN) m_s1++;
               m_last = 1; m_bs = 1; m_st = 3; m_cnt = 0;
            end else begin
               if (m_vx < 0 && m_bx - BS / 2 > LFACE && nx - BS / 2 <= LFACE &&
                   iabs(ny - op1) <= (PH + BS) / 2) begin
                  nx = LFACE + BS / 2; m_vx = 1; m_bp = 1;
               end else if (m_vx > 0 && m_bx + BS / 2 < RFACE && nx + BS / 2 >= RFACE &&
                            iabs(ny - op2) <= (PH + BS) / 2) begin
                  nx = RFACE - BS / 2; m_vx = -1; m_bp = 1;
               end
               if (ny - BS / 2 < 0) begin
                  ny = BS / 2; m_vy = 1; m_bw = 1;
               end else if (ny + BS / 2 > FH - 1) begin
                  ny = FH - 1 - BS / 2; m_vy = -1; m_bw = 1;
               end
               m_bx = nx;
               m_by = ny;
            end
         end
         3: begin
            m_cnt++;
            if (m_cnt == PF) begin
               if ((m_last == 2 ? m_s2 : m_s1) == WIN) m_st = 4;
               else if (m_last == 2) begin m_st = 0; m_bx = LFACE + BS / 2; m_by = m_p1y; end
               else begin m_st = 1; m_bx = RFACE - BS / 2; m_by = m_p2y; end
            end
         end
         default: begin
            if (s1ev || s2ev) begin
               m_s1 = 0; m_s2 = 0; m_p1y = FH / 2; m_p2y = FH / 2;
               m_bx = LFACE + BS / 2; m_by = FH / 2; m_st = 0;
            end
         end
      endcase
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_p1y = FH / 2; m_p2y = FH / 2; m_bx = LFACE + BS / 2; m_by = FH / 2;
         m_vx = 1; m_vy = 1; m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_last = 0;
         m_bp = 0; m_bw = 0; m_bs = 0; m_prev1 = 0; m_prev2 = 0; m_pend1 = 0; m_pend2 = 0;
      end else begin
         e1 = m_pend1 | (p1_srv & !m_prev1);
         e2 = m_pend2 | (p2_srv & !m_prev2);
         m_prev1 = p1_srv;
         m_prev2 = p2_srv;
         m_bp = 0; m_bw = 0; m_bs = 0;
         if (frame_tick) begin
            m_pend1 = 0; m_pend2 = 0;
            model_frame(e1, e2);
         end else begin
            m_pend1 = e1; m_pend2 = e2;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         if (int'(p1_y) != m_p1y || int'(p2_y) != m_p2y || int'(ball_x) != m_bx ||
             int'(ball_y) != m_by || int'(score1) != m_s1 || int'(score2) != m_s2 ||
             int'(state) != m_st || beep_pad != m_bp || beep_wall != m_bw ||
             beep_score != m_bs) begin
            errors++;
            $display("FAIL outputs t=%0t got p1y=%0d p2y=%0d bx=%0d by=%0d s=%0d/%0d st=%0d b=%b%b%b want p1y=%0d p2y=%0d bx=%0d by=%0d s=%0d/%0d st=%0d b=%b%b%b",
                     $time, p1_y, p2_y, ball_x, ball_y, score1, score2, state, beep_pad,
                     beep_wall, beep_score, m_p1y, m_p2y, m_bx, m_by, m_s1, m_s2, m_st,
                     m_bp, m_bw, m_bs);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check_lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick_done();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!frame_tick && n < 20);
      if (!frame_tick) begin
         checks++;
         errors++;
         $display("FAIL tick_wait got no tick want tick within 20 cycles");
      end
      @(negedge clk);
   endtask

   initial begin
      bit counting, pt_done, got_over;
      int pt_n;
      rst = 1; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; p1_srv = 0; p2_srv = 0;
      @(negedge clk);
      rst = 0;
      chk_on = 1;
      check_lit("rst_p1_y", p1_y, 240);
      check_lit("rst_p2_y", p2_y, 240);
      check_lit("rst_ball_x", ball_x, 48);
      check_lit("rst_ball_y", ball_y, 240);
      check_lit("rst_scores", {score1, score2}, 0);
      check_lit("rst_state", state, 0);
      check_lit("rst_beeps", {beep_pad, beep_wall, beep_score}, 0);

      p1_up = 1;
      for (int k = 1; k <= 20; k++) begin
         tick_done();
         if (k == 1) check_lit("p1_up_1", p1_y, 224);
         if (k == 13) check_lit("p1_up_13", p1_y, 32);
         if (k == 14) check_lit("p1_up_clamp", p1_y, 25);
      end
      check_lit("p1_up_hold", p1_y, 25);
      check_lit("serve_ball_tracks", ball_y, 25);
      p1_dn = 1; p2_up = 1; p2_dn = 1;
      tick_done();
      check_lit("both_p1", p1_y, 25);
      check_lit("both_p2", p2_y, 240);
      p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;

      p2_srv = 1;
      tick_done();
      check_lit("p2_srv_ignored", state, 0);
      p2_srv = 0;
      p1_srv = 1;
      tick_done();
      check_lit("serve_state", state, 2);
      check_lit("serve_x", ball_x, 48);
      p1_srv = 0;
      tick_done();
      check_lit("first_move_x", ball_x, 56);

      // Random play with a reset dropped in mid-game.
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         rst = (c == 4000);
         p1_up = ($urandom_range(0, 2) == 0);
         p1_dn = ($urandom_range(0, 2) == 0);
         p2_up = ($urandom_range(0, 2) == 0);
         p2_dn = ($urandom_range(0, 2) == 0);
         p1_srv = ($urandom_range(0, 7) == 0);
         p2_srv = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;

      // p1 dodges the ball, p2 follows it, both keep serving: play runs to game over.
      counting = 0; pt_done = 0; got_over = 0; pt_n = 0;
      for (int i = 0; i < 20000 && !got_over; i++) begin
         p1_up = (ball_y >= 240);
         p1_dn = (ball_y < 240);
         p2_up = (int'(ball_y) + 8 < int'(p2_y));
         p2_dn = (int'(ball_y) > int'(p2_y) + 8);
         p1_srv = ~p1_srv;
         p2_srv = ~p2_srv;
         tick_done();
         if (!pt_done) begin
            if (counting) begin
               pt_n++;
               if (state != 3) begin
                  check_lit("point_pause_ticks", pt_n, 60);
                  counting = 0;
                  pt_done = 1;
               end
            end else if (state == 3) begin
               counting = 1;
               pt_n = 0;
            end
         end
         if (state == 4) got_over = 1;
      end
      if (!got_over) begin
         checks++;
         errors++;
         $display("FAIL gameover_wait got state %0d want 4 within 20000 ticks", state);
      end else begin
         check_lit("winner_score", (score1 > score2) ? score1 : score2, 9);
         p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; p1_srv = 0; p2_srv = 0;
         tick_done();
         check_lit("gameover_frozen", state, 4);
         p2_srv = 1;
         tick_done();
         check_lit("restart_state", state, 0);
         check_lit("restart_scores", {score1, score2}, 0);
         check_lit("restart_p1_y", p1_y, 240);
         check_lit("restart_p2_y", p2_y, 240);
         check_lit("restart_ball_x", ball_x, 48);
         p2_srv = 0;
      end
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
